// File: rtl/req_deserializer_pkg.sv
// Shared definitions for the request deserializer: word geometry,
// header field positions and the controller state encoding.
package req_deserializer_pkg;

  localparam int WORD_W      = 32;

  // Header word layout: method id in the upper half, total word count
  // (header included) in the lower half.
  localparam int HDR_ID_MSB  = 31;
  localparam int HDR_ID_LSB  = 16;
  localparam int HDR_CNT_MSB = 15;
  localparam int HDR_CNT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

  function automatic logic [15:0] hdr_count(input logic [WORD_W-1:0] w);
    return w[HDR_CNT_MSB:HDR_CNT_LSB];
  endfunction

endpackage

// File: rtl/req_deserializer.sv
// Request deserializer: gathers a header word plus N-1 payload words from a
// 32-bit enq stream into one msgWidth-bit message and hands it downstream.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a header word
//   COLLECT | header stored, waiting for the remaining payload words
//   SEND    | full message held, offered downstream until taken
//
// Malformed headers (count 0 or larger than the buffer) are dropped and
// latch protoErr until reset.
module req_deserializer
  import req_deserializer_pkg::*;
#(
  parameter int msgWidth = 128
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                in_enq__ENA,
  input  logic [31:0]         in_enq_v,
  output logic                in_enq__RDY,
  output logic                pipe_enq__ENA,
  output logic [msgWidth-1:0] pipe_enq_v,
  input  logic                pipe_enq__RDY,
  output logic                protoErr
);

  localparam int MAX_WORDS = msgWidth / WORD_W;
  localparam int IDX_W     = $clog2(MAX_WORDS) + 1;
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_e              state_q, state_d;
  logic [msgWidth-1:0] msg_q, msg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                proto_err_q, proto_err_d;

  logic [15:0]         hdr_n;
  logic                hdr_ok;
  logic                accept;

  assign hdr_n  = hdr_count(in_enq_v);
  assign hdr_ok = (hdr_n != 16'd0) && (hdr_n <= MAX_N);

  // Ready is gated by reset so upstream never sees a ready while held in reset.
  assign in_enq__RDY   = nRST && (state_q != ST_SEND);
  assign accept        = in_enq__ENA && in_enq__RDY;
  assign pipe_enq__ENA = (state_q == ST_SEND) && pipe_enq__RDY;
  assign pipe_enq_v    = msg_q;
  assign protoErr      = proto_err_q;

  // Next-state, buffer fill and error flag logic.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!hdr_ok) begin
            proto_err_d = 1'b1;
          end else begin
            msg_d[WORD_W-1:0] = in_enq_v;
            cnt_d             = hdr_n[IDX_W-1:0];
            idx_d             = IDX_W'(1);
            state_d           = (hdr_n == 16'd1) ? ST_SEND : ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (accept) begin
          msg_d[idx_q*WORD_W +: WORD_W] = in_enq_v;
          if (idx_q == cnt_q - IDX_W'(1)) begin
            state_d = ST_SEND;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_SEND: begin
        if (pipe_enq__RDY) begin
          msg_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        msg_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, message buffer and sticky error registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      msg_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_req_deserializer.sv
// Bench for req_deserializer: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a message-level
// reference model.
module tb_req_deserializer;

  localparam int MSGW = 128;
  localparam int MAXW = MSGW / 32;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            in_ena;
  logic [31:0]     in_v;
  logic            in_rdy;
  logic            pipe_ena;
  logic [MSGW-1:0] pipe_v;
  logic            pipe_rdy;
  logic            proto_err;

  always #5 CLK = ~CLK;

  req_deserializer #(.msgWidth(MSGW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .pipe_enq__ENA(pipe_ena),
    .pipe_enq_v   (pipe_v),
    .pipe_enq__RDY(pipe_rdy),
    .protoErr     (proto_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkv(input string name, input logic [MSGW-1:0] act, input logic [MSGW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic e, input logic [31:0] v, input logic r);
    in_ena   = e;
    in_v     = v;
    pipe_rdy = r;
    #1;
  endtask

  // ---------------- reference model (message level) ----------------
  logic [MSGW-1:0] pend[$];
  logic [31:0]     acc[$];
  logic [31:0]     tx_q[$];
  int              need;
  logic            err_m;

  task automatic model_reset();
    pend.delete();
    acc.delete();
    need  = 0;
    err_m = 1'b0;
  endtask

  task automatic model_finish();
    logic [MSGW-1:0] m;
    m = '0;
    foreach (acc[i]) m[32*i +: 32] = acc[i];
    pend.push_back(m);
    acc.delete();
    need = 0;
  endtask

  task automatic model_accept(input logic [31:0] w);
    int n;
    if (need == 0) begin
      n = int'(w[15:0]);
      if (n == 0 || n > MAXW) begin
        err_m = 1'b1;
      end else begin
        acc.push_back(w);
        need = n;
        if (n == 1) model_finish();
      end
    end else begin
      acc.push_back(w);
      if (acc.size() == need) model_finish();
    end
  endtask

  task automatic gen_msg();
    int n;
    if ($urandom_range(0, 7) == 0) begin
      n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXW + 1, 16'hFFFF));
      tx_q.push_back({16'($urandom), 16'(n)});
    end else begin
      n = int'($urandom_range(1, MAXW));
      tx_q.push_back({16'($urandom), 16'(n)});
      for (int i = 1; i < n; i++) tx_q.push_back($urandom);
    end
  endtask

  task automatic do_reset();
    nRST     = 1'b0;
    in_ena   = 1'b0;
    pipe_rdy = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            ena;
    logic [31:0]     v;
    logic            prdy;
    logic            x_rdy;
    logic            x_pena;
    logic [MSGW-1:0] x_msg;
    logic            x_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0001_0001, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 128'h0001_0001, 1'b0};
    vecs[2] = '{1'b1, 32'h0004_0002, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0009, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 128'h0000_0009_0004_0002, 1'b0};
    vecs[5] = '{1'b1, 32'h0002_0000, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
    vecs[6] = '{1'b1, 32'h0002_0005, 1'b1, 1'b1, 1'b0, 128'h0, 1'b1};
    vecs[7] = '{1'b1, 32'h0007_0001, 1'b1, 1'b1, 1'b0, 128'h0, 1'b1};
    vecs[8] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 128'h0007_0001, 1'b1};
    vecs[9] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 128'h0, 1'b1};

    // Reset state
    nRST     = 1'b0;
    in_ena   = 1'b0;
    in_v     = '0;
    pipe_rdy = 1'b0;
    tick();
    tick();
    chk1("rst_in_rdy", in_rdy, 1'b0);
    chk1("rst_pipe_ena", pipe_ena, 1'b0);
    chkv("rst_pipe_v", pipe_v, '0);
    chk1("rst_proto_err", proto_err, 1'b0);
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ena, vecs[i].v, vecs[i].prdy);
      chk1($sformatf("vec%0d_in_rdy", i), in_rdy, vecs[i].x_rdy);
      chk1($sformatf("vec%0d_pipe_ena", i), pipe_ena, vecs[i].x_pena);
      chk1($sformatf("vec%0d_proto_err", i), proto_err, vecs[i].x_err);
      if (vecs[i].x_pena) chkv($sformatf("vec%0d_pipe_v", i), pipe_v, vecs[i].x_msg);
      tick();
    end

    // Back-pressure: full 4-word message held for 10 cycles
    do_reset();
    begin
      logic [31:0]     w[4];
      logic [MSGW-1:0] exp_m;
      int              xfers;
      w[0] = 32'h0003_0004; w[1] = 32'h0000_000A; w[2] = 32'h0000_000B; w[3] = 32'h0000_000C;
      exp_m = {w[3], w[2], w[1], w[0]};
      xfers = 0;
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, w[i], 1'b0);
        chk1("bp_fill_in_rdy", in_rdy, 1'b1);
        tick();
      end
      for (int i = 0; i < 10; i++) begin
        drive(1'b0, 32'h0, 1'b0);
        chk1("bp_hold_in_rdy", in_rdy, 1'b0);
        chk1("bp_hold_pipe_ena", pipe_ena, 1'b0);
        chkv("bp_hold_pipe_v", pipe_v, exp_m);
        tick();
      end
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, 32'h0, 1'b1);
        if (pipe_ena) begin
          xfers++;
          chkv("bp_release_pipe_v", pipe_v, exp_m);
        end
        tick();
      end
      chkv("bp_xfer_count", MSGW'(xfers), MSGW'(1));
      drive(1'b0, 32'h0, 1'b1);
      chk1("bp_after_in_rdy", in_rdy, 1'b1);
      chkv("bp_after_cleared", pipe_v, '0);
    end

    // Reset after 2 of 3 words, then a 1-word message
    drive(1'b1, 32'h0005_0003, 1'b1);
    tick();
    drive(1'b1, 32'h0000_0011, 1'b1);
    tick();
    in_ena = 1'b0;
    nRST   = 1'b0;
    #1;
    chk1("rstc_in_rdy", in_rdy, 1'b0);
    chk1("rstc_pipe_ena", pipe_ena, 1'b0);
    chk1("rstc_proto_err", proto_err, 1'b0);
    chkv("rstc_pipe_v", pipe_v, '0);
    tick();
    chk1("rstc_hold_pipe_ena", pipe_ena, 1'b0);
    nRST = 1'b1;
    drive(1'b1, 32'h0009_0001, 1'b1);
    chk1("rstc_first_in_rdy", in_rdy, 1'b1);
    chk1("rstc_first_pipe_ena", pipe_ena, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk1("rstc_next_pipe_ena", pipe_ena, 1'b1);
    chkv("rstc_next_pipe_v", pipe_v, 128'h0009_0001);
    chk1("rstc_next_proto_err", proto_err, 1'b0);
    tick();

    // Reset while a message is held in SEND
    drive(1'b1, 32'h000A_0001, 1'b0);
    tick();
    in_ena = 1'b0;
    nRST   = 1'b0;
    #1;
    chk1("rsts_pipe_ena", pipe_ena, 1'b0);
    chkv("rsts_pipe_v", pipe_v, '0);
    tick();
    nRST = 1'b1;
    drive(1'b0, 32'h0, 1'b1);
    chk1("rsts_after_pipe_ena", pipe_ena, 1'b0);
    chk1("rsts_after_in_rdy", in_rdy, 1'b1);
    tick();

    // Back-to-back 1-word messages
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, {16'(k + 16), 16'h0001}, 1'b1);
      chk1("b2b_in_rdy", in_rdy, 1'b1);
      chk1("b2b_idle_pipe_ena", pipe_ena, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      chk1("b2b_pipe_ena", pipe_ena, 1'b1);
      chk1("b2b_send_in_rdy", in_rdy, 1'b0);
      chkv("b2b_pipe_v", pipe_v, MSGW'({16'(k + 16), 16'h0001}));
      tick();
    end

    // Randomized traffic against the reference model
    do_reset();
    tx_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic prdy, e, x_rdy, x_pena;
      if (tx_q.size() == 0) gen_msg();
      prdy   = ($urandom_range(0, 9) < 7);
      x_rdy  = (pend.size() == 0);
      e      = x_rdy && ($urandom_range(0, 9) < 6);
      x_pena = (pend.size() != 0) && prdy;
      drive(e, e ? tx_q[0] : $urandom, prdy);
      chk1("rnd_in_rdy", in_rdy, x_rdy);
      chk1("rnd_pipe_ena", pipe_ena, x_pena);
      chk1("rnd_proto_err", proto_err, err_m);
      if (x_pena) chkv("rnd_pipe_v", pipe_v, pend[0]);
      if (x_pena) void'(pend.pop_front());
      if (e) model_accept(tx_q.pop_front());
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
